// File: rtl/tracer_pkg.sv
// Shared types and constants for the commit tracer: FSM states, trace record layout,
// record kinds and a saturating counter helper.
package tracer_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HALTED  = 2'b01,
        ST_TIMEOUT = 2'b10
    } state_t;

    localparam logic TRACE_REG = 1'b0;
    localparam logic TRACE_MEM = 1'b1;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    localparam int TRACE_W = $bits(trace_rec_t);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; head read combinationally at the read pointer.
// A push while full is accepted only if a pop happens in the same cycle, otherwise it is dropped and flagged.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign drop    = push & full & ~pop_en;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/commit_tracer.sv
// Consumer of the CPU commit port: qualifies retirements, counts cycles/instructions,
// stops on ebreak or watchdog timeout, and queues register/memory write records for a trace port.
module commit_tracer
    import tracer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   global_en,
    output logic                   cpu_en,
    input  logic                   commit,
    input  logic [31:0]            commit_pc,
    input  logic [31:0]            commit_instr,
    input  logic                   commit_halt,
    input  logic                   commit_reg_we,
    input  logic [4:0]             commit_reg_wa,
    input  logic [31:0]            commit_reg_wd,
    input  logic                   commit_dmem_we,
    input  logic [31:0]            commit_dmem_wa,
    input  logic [31:0]            commit_dmem_wd,
    output logic [1:0]             state,
    output logic [31:0]            cycle_cnt,
    output logic [31:0]            instret_cnt,
    output logic [31:0]            halt_pc,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic                   trace_kind,
    output logic [31:0]            trace_pc,
    output logic [31:0]            trace_addr,
    output logic [31:0]            trace_data,
    output logic [$clog2(DEPTH):0] trace_count,
    output logic                   trace_overflow
);
    localparam int IW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    state_t        state_q;
    state_t        state_d;
    logic          en_d;
    logic [IW-1:0] idle_q;
    logic          run;
    logic          tick;
    logic          acc;
    logic          idle_tick;
    logic          wd_fire;
    trace_rec_t    rec;
    logic          rec_vld;
    trace_rec_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic          unused_ok;

    // The instruction word itself carries nothing the trace needs; halt comes via commit_halt.
    assign unused_ok = ^{commit_instr, fifo_full};

    assign run       = (state_q == ST_RUN);
    assign tick      = run & global_en;
    // en_d marks that the CPU advanced on the last edge, so its commit outputs are fresh.
    assign acc       = commit & en_d & run;
    assign idle_tick = tick & ~acc;
    assign wd_fire   = idle_tick & (idle_q == IDLE_LAST);

    assign cpu_en = tick;
    assign state  = state_q;

    always_comb begin
        state_d = state_q;
        if (acc && commit_halt) begin
            state_d = ST_HALTED;
        end else if (wd_fire) begin
            state_d = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            en_d           <= 1'b0;
            idle_q         <= '0;
            cycle_cnt      <= '0;
            instret_cnt    <= '0;
            halt_pc        <= '0;
            trace_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            en_d    <= cpu_en;
            if (tick) cycle_cnt <= sat_inc(cycle_cnt);
            if (acc)  instret_cnt <= sat_inc(instret_cnt);
            if (acc && commit_halt) halt_pc <= commit_pc;
            if (acc) begin
                idle_q <= '0;
            end else if (idle_tick) begin
                idle_q <= idle_q + IDLE_ONE;
            end
            if (fifo_drop) trace_overflow <= 1'b1;
        end
    end

    // A memory write takes precedence; x0 writes, branches and ebreak leave no record.
    always_comb begin
        rec     = '0;
        rec_vld = 1'b0;
        if (acc) begin
            if (commit_dmem_we) begin
                rec_vld = 1'b1;
                rec     = '{kind: TRACE_MEM, pc: commit_pc, addr: commit_dmem_wa, data: commit_dmem_wd};
            end else if (commit_reg_we && (commit_reg_wa != 5'd0)) begin
                rec_vld = 1'b1;
                rec     = '{kind: TRACE_REG, pc: commit_pc, addr: {27'b0, commit_reg_wa}, data: commit_reg_wd};
            end
        end
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rec_vld),
        .push_dat (rec),
        .pop      (trace_ready),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (trace_count),
        .drop     (fifo_drop)
    );

    assign trace_valid = ~fifo_empty;
    assign trace_kind  = head.kind;
    assign trace_pc    = head.pc;
    assign trace_addr  = head.addr;
    assign trace_data  = head.data;

endmodule

// File: tb/tb_commit_tracer.sv
// Self-checking bench for commit_tracer with DEPTH=4, TIMEOUT=8; expected trace records
// are queued as commits are driven and compared as the trace port drains.
module tb_commit_tracer;
    import tracer_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        global_en = 1'b0;
    logic        cpu_en;
    logic        commit = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_instr = '0;
    logic        commit_halt = 1'b0;
    logic        commit_reg_we = 1'b0;
    logic [4:0]  commit_reg_wa = '0;
    logic [31:0] commit_reg_wd = '0;
    logic        commit_dmem_we = 1'b0;
    logic [31:0] commit_dmem_wa = '0;
    logic [31:0] commit_dmem_wd = '0;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    logic [31:0] halt_pc;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic        trace_kind;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [$clog2(DEPTH):0] trace_count;
    logic        trace_overflow;

    int checks = 0;
    int failures = 0;
    trace_rec_t exp_q[$];
    logic exp_acc = 1'b1;

    commit_tracer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .global_en(global_en), .cpu_en(cpu_en),
        .commit(commit), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_halt(commit_halt), .commit_reg_we(commit_reg_we),
        .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd),
        .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa),
        .commit_dmem_wd(commit_dmem_wd), .state(state), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt), .halt_pc(halt_pc), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_kind(trace_kind), .trace_pc(trace_pc),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_count(trace_count),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        commit = 1'b0; commit_halt = 1'b0; commit_reg_we = 1'b0; commit_dmem_we = 1'b0;
        trace_ready = 1'b0; global_en = 1'b1; rst = 1'b1;
        step;
        rst = 1'b0;
        step;
        exp_q.delete();
        exp_acc = 1'b1;
    endtask

    // Presents one commit for a cycle; the record it should produce goes to the scoreboard.
    task automatic drive_commit(input logic [31:0] pc, input logic [31:0] instr, input logic halt,
                                input logic reg_we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic mem_we, input logic [31:0] ma, input logic [31:0] md);
        trace_rec_t r;
        logic has;
        commit = 1'b1; commit_pc = pc; commit_instr = instr; commit_halt = halt;
        commit_reg_we = reg_we; commit_reg_wa = wa; commit_reg_wd = wd;
        commit_dmem_we = mem_we; commit_dmem_wa = ma; commit_dmem_wd = md;
        has = 1'b0;
        r = '0;
        if (mem_we) begin
            has = 1'b1; r = '{kind: TRACE_MEM, pc: pc, addr: ma, data: md};
        end else if (reg_we && wa != 5'd0) begin
            has = 1'b1; r = '{kind: TRACE_REG, pc: pc, addr: {27'b0, wa}, data: wd};
        end
        if (exp_acc && has && exp_q.size() < DEPTH) exp_q.push_back(r);
        step;
    endtask

    task automatic reg_wr(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        drive_commit(pc, 32'h0000_0013, 1'b0, 1'b1, wa, wd, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain_and_score(input string name, input int exp_n);
        int seen;
        trace_rec_t e;
        trace_rec_t got;
        seen = 0;
        trace_ready = 1'b1;
        for (int n = 0; n < 4 * DEPTH + 8; n++) begin
            if (trace_valid) begin
                got = '{kind: trace_kind, pc: trace_pc, addr: trace_addr, data: trace_data};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_unexpected_record actual=%h required=none", name, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL %s_record actual=%h required=%h", name, got, e);
                    end
                end
                seen++;
            end else if (exp_q.size() == 0) begin
                break;
            end
            step;
        end
        trace_ready = 1'b0;
        checks++;
        if (seen != exp_n || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain_count actual=%0d required=%0d (left %0d)", name, seen, exp_n, exp_q.size());
        end
    endtask

    task automatic test_reset;
        global_en = 1'b1; rst = 1'b1;
        step;
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL rst_state actual=%b required=00", state); end
        checks++; if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0 || halt_pc !== 32'd0) begin failures++;
            $display("FAIL rst_counters actual=%h/%h/%h required=0/0/0", cycle_cnt, instret_cnt, halt_pc); end
        checks++; if (trace_valid !== 1'b0 || trace_count !== '0 || trace_overflow !== 1'b0) begin failures++;
            $display("FAIL rst_fifo actual=%b/%0d/%b required=0/0/0", trace_valid, trace_count, trace_overflow); end
        rst = 1'b0;
        step;
        reg_wr(32'h0, 5'd1, 32'h11);
        reg_wr(32'h4, 5'd2, 32'h22);
        reg_wr(32'h8, 5'd3, 32'h33);
        commit = 1'b0;
        checks++; if (trace_count !== 3'd3) begin failures++; $display("FAIL pre_rst_count actual=%0d required=3", trace_count); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        exp_q.delete();
        checks++; if (state !== 2'b00 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin failures++;
            $display("FAIL midrst_state actual=%b/%h/%h required=00/0/0", state, cycle_cnt, instret_cnt); end
        checks++; if (trace_valid !== 1'b0 || trace_count !== '0 || trace_overflow !== 1'b0) begin failures++;
            $display("FAIL midrst_fifo actual=%b/%0d/%b required=0/0/0", trace_valid, trace_count, trace_overflow); end
        step;
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL midrst_cpu_en_hi actual=%b required=1", cpu_en); end
        global_en = 1'b0;
        #1;
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL midrst_cpu_en_lo actual=%b required=0", cpu_en); end
        global_en = 1'b1;
    endtask

    task automatic test_order;
        do_reset;
        reg_wr(32'h0, 5'd1, 32'd5);
        drive_commit(32'h4, 32'h0070_2023, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'd7);
        reg_wr(32'h8, 5'd0, 32'd9);
        commit = 1'b0;
        checks++; if (instret_cnt !== 32'd3) begin failures++; $display("FAIL order_instret actual=%0d required=3", instret_cnt); end
        drain_and_score("order", 2);
    endtask

    task automatic test_halt;
        do_reset;
        drive_commit(32'h40, EBREAK, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        checks++; if (state !== ST_HALTED || halt_pc !== 32'h40) begin failures++;
            $display("FAIL halt_state actual=%b/%h required=01/00000040", state, halt_pc); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL halt_cpu_en actual=%b required=0", cpu_en); end
        checks++; if (cycle_cnt !== 32'd2) begin failures++; $display("FAIL halt_cycle actual=%0d required=2", cycle_cnt); end
        exp_acc = 1'b0;
        reg_wr(32'h44, 5'd5, 32'h1);
        commit = 1'b0;
        step;
        checks++; if (instret_cnt !== 32'd1) begin failures++; $display("FAIL halt_instret actual=%0d required=1", instret_cnt); end
        checks++; if (state !== ST_HALTED || trace_count !== '0) begin failures++;
            $display("FAIL halt_younger actual=%b/%0d required=01/0", state, trace_count); end
        checks++; if (cycle_cnt !== 32'd2) begin failures++; $display("FAIL halt_cycle_frozen actual=%0d required=2", cycle_cnt); end
    endtask

    task automatic test_overflow;
        trace_rec_t e;
        trace_rec_t got;
        do_reset;
        for (int i = 1; i <= 5; i++) reg_wr(32'(i * 4), 5'(i), 32'(16 + i));
        commit = 1'b0;
        checks++; if (trace_count !== 3'd4 || trace_overflow !== 1'b1) begin failures++;
            $display("FAIL ovf_full actual=%0d/%b required=4/1", trace_count, trace_overflow); end
        trace_ready = 1'b1;
        got = '{kind: trace_kind, pc: trace_pc, addr: trace_addr, data: trace_data};
        e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL ovf_head actual=%h required=%h", got, e); end
        reg_wr(32'h18, 5'd6, 32'h16);
        commit = 1'b0;
        trace_ready = 1'b0;
        checks++; if (trace_count !== 3'd4 || trace_overflow !== 1'b1) begin failures++;
            $display("FAIL ovf_pushpop actual=%0d/%b required=4/1", trace_count, trace_overflow); end
        drain_and_score("ovf", 4);
    endtask

    task automatic test_watchdog;
        do_reset;
        repeat (4) step;
        reg_wr(32'h20, 5'd0, 32'h0);
        commit = 1'b0;
        repeat (7) step;
        checks++; if (state !== ST_RUN) begin failures++; $display("FAIL wd_early actual=%b required=00", state); end
        step;
        checks++; if (state !== ST_TIMEOUT || cpu_en !== 1'b0) begin failures++;
            $display("FAIL wd_fire actual=%b/%b required=10/0", state, cpu_en); end
        checks++; if (cycle_cnt !== 32'd14) begin failures++; $display("FAIL wd_cycle actual=%0d required=14", cycle_cnt); end
        step;
        checks++; if (cycle_cnt !== 32'd14) begin failures++; $display("FAIL wd_cycle_frozen actual=%0d required=14", cycle_cnt); end
    endtask

    task automatic test_held_commit;
        do_reset;
        global_en = 1'b0;
        reg_wr(32'h60, 5'd7, 32'd3);
        checks++; if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd1) begin failures++;
            $display("FAIL held_first actual=%0d/%0d required=1/1", instret_cnt, cycle_cnt); end
        repeat (2) step;
        checks++; if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd1) begin failures++;
            $display("FAIL held_hold actual=%0d/%0d required=1/1", instret_cnt, cycle_cnt); end
        commit = 1'b0;
        global_en = 1'b1;
        step;
        checks++; if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd2) begin failures++;
            $display("FAIL held_resume actual=%0d/%0d required=1/2", instret_cnt, cycle_cnt); end
        drain_and_score("held", 1);
    endtask

    initial begin
        test_reset;
        test_order;
        test_halt;
        test_overflow;
        test_watchdog;
        test_held_commit;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commit_tracer.md
Name: commit_tracer

Overview:
- Consumer end of the CPU commit/debug interface. Qualifies each retired instruction, keeps cycle and retired-instruction counters, and detects halt (ebreak) or watchdog timeout.
- Gates the CPU's global enable once execution stops.
- Buffers register-write and data-memory-write commit records in a FIFO, drained by a valid/ready trace port for the debug UART or bench.

Parameters:
DEPTH, 16, trace FIFO entries (power of 2, >=2)
TIMEOUT, 1024, enabled cycles without a retired instruction before TIMEOUT state (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
global_en  in  1  run enable from the board/bench
cpu_en  out  1  enable driven to the CPU's global_en
commit  in  1  commit strobe from the CPU
commit_pc  in  32  retired PC
commit_instr  in  32  retired instruction
commit_halt  in  1  retired instruction is ebreak
commit_reg_we  in  1  register write
commit_reg_wa  in  5  register address
commit_reg_wd  in  32  register data
commit_dmem_we  in  1  memory write
commit_dmem_wa  in  32  word-aligned memory address
commit_dmem_wd  in  32  memory data
state  out  2  00 RUN, 01 HALTED, 10 TIMEOUT
cycle_cnt  out  32  enabled RUN cycles
instret_cnt  out  32  retired instructions
halt_pc  out  32  PC of the halting instruction
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_kind  out  1  0 register write, 1 memory write
trace_pc  out  32  head PC
trace_addr  out  32  head address (zero-extended register number, or memory address)
trace_data  out  32  head data
trace_count  out  $clog2(DEPTH)+1  occupancy
trace_overflow  out  1  sticky: a record was dropped

Behaviour:
- Reset (async, any time, including mid-drain) values:
  - state=RUN
  - cycle_cnt, instret_cnt, halt_pc = 0
  - FIFO empty: trace_valid=0, trace_count=0
  - trace_overflow=0
  - idle counter=0, en_d=0
- cpu_en = global_en & (state==RUN). Combinational from the registered state.
- en_d: cpu_en registered each cycle.
- Commit qualification:
  - The CPU's commit outputs hold their value while its enable is low.
  - acc = commit & en_d & (state==RUN).
  - A commit held across disabled cycles is counted exactly once.
- cycle_cnt: +1 on each cycle with state==RUN & global_en. Saturates at 0xFFFFFFFF.
- instret_cnt: +1 on each cycle with acc, including the halt instruction. Saturates.
- Halt:
  - acc & commit_halt → state=HALTED, halt_pc=commit_pc on the same edge.
  - cpu_en falls the following cycle.
  - Younger commits arriving afterwards are ignored.
  - HALTED is terminal until reset.
- Watchdog:
  - idle counts cycles with state==RUN & global_en & !acc, and clears on acc.
  - When idle reaches TIMEOUT-1 and the current cycle also qualifies → state=TIMEOUT (terminal until reset).
  - If halt and timeout occur in the same cycle, halt wins.
- Record generation, on acc only:
  - commit_dmem_we=1 → kind 1, addr=commit_dmem_wa, data=commit_dmem_wd.
  - Else commit_reg_we=1 and commit_reg_wa!=0 → kind 0, addr={27'b0,wa}, data=commit_reg_wd.
  - Otherwise no record. Writes to x0, branches and halt produce no record.
- FIFO:
  - Push occurs on a record.
  - Pop occurs on trace_valid & trace_ready.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - Push when full with no pop: record dropped, trace_overflow set (sticky until reset).
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH.
  - Head outputs are registered or from RAM read at the head pointer; they are valid whenever trace_valid=1 and are don't-care otherwise.
  - Draining continues in HALTED and TIMEOUT.
- Record order matches commit order.

Decomposition:
- Shared package (tracer_pkg):
  - state encodings RUN/HALTED/TIMEOUT
  - TRACE_REG/TRACE_MEM kind constants
  - EBREAK constant 32'h00100073, used by the bench
  - trace record packing: kind, pc, addr, data = 97 bits
- Sub-module trace_fifo:
  - generic synchronous FIFO, parameters WIDTH and DEPTH
  - push/pop/full/empty/count, async reset
  - drop-on-full signalled to the parent
- Counters, watchdog and FSM stay in commit_tracer.

Test Plan:
- Reset mid-stream: 3 records queued, assert rst for 1 cycle → state=00, counters 0, trace_valid=0, trace_overflow=0, cpu_en=global_en next cycle.
- Three commits in order:
  - x1←5 at pc 0x0
  - sw 7→0x100 at pc 0x4
  - x0←9 at pc 0x8
  - → instret_cnt=3; records {0,0x0,1,5} then {1,0x4,0x100,7}; no third record.
- Halt: acc with commit_halt at pc 0x40, then a commit at pc 0x44 → state=01, halt_pc=0x40, instret counts 0x40 only, cpu_en=0 from the next cycle, cycle_cnt frozen.
- Overflow, DEPTH=4, trace_ready=0:
  - 5 register writes → count=4, overflow=1, 5th record lost.
  - Then push and pop in the same cycle while full → count stays 4, head advances.
- Watchdog, TIMEOUT=8, global_en=1:
  - commit at idle cycle 6 clears the counter.
  - then 8 commit-free cycles → state=10 at the 8th cycle, cpu_en=0.
- Held commit: commit=1 while global_en drops for 3 cycles → instret +1 only, cycle_cnt frozen for those 3 cycles.
